// File: rtl/mdl_axis_coef_unpack_if.sv
// Stream-in / coefficient-out bundle for mdl_axis_coef_unpack.
// valid/ready: a transfer happens on a rising edge with both high; a source holds its payload stable while valid && !ready.
interface mdl_axis_coef_unpack_if #(
    parameter int PRM_AXIS_WIDTH = 64,
    parameter int PRM_COEF_WIDTH = 32,
    parameter int PRM_ADDR       = 12
);
    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [PRM_AXIS_WIDTH-1:0]   s_axis_tdata;
    logic [PRM_AXIS_WIDTH/8-1:0] s_axis_tkeep;
    logic                        s_axis_tlast;
    logic                        coef_valid;
    logic                        coef_ready;
    logic [PRM_COEF_WIDTH-1:0]   coef_data;
    logic [PRM_ADDR-1:0]         coef_addr;
    logic [3:0]                  coef_poly;
    logic                        coef_last_poly;
    logic                        coef_last;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, coef_ready,
        output s_axis_tready, coef_valid, coef_data, coef_addr, coef_poly, coef_last_poly, coef_last
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, coef_ready,
        input  s_axis_tready, coef_valid, coef_data, coef_addr, coef_poly, coef_last_poly, coef_last
    );
endinterface

// File: rtl/mdl_axis_coef_unpack.sv
// Splits AXI-Stream beats into tagged coefficients for a frame of 1..PRM_MAX_POLY polynomials,
// checking frame length against TLAST and flagging partially-kept lanes.
module mdl_axis_coef_unpack #(
    parameter int PRM_AXIS_WIDTH = 64,
    parameter int PRM_COEF_WIDTH = 32,
    parameter int PRM_COEFFS     = 4096,
    parameter int PRM_ADDR       = 12,
    parameter int PRM_MAX_POLY   = 4
) (
    input  logic                  iSYS_CLK,
    input  logic                  iSYS_RST,
    input  logic                  iCTL_START,
    input  logic [3:0]            iCTL_NPOLY,
    mdl_axis_coef_unpack_if.slave bus,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oERR_LEN,
    output logic                  oERR_KEEP,
    output logic [1:0]            oDBG_STATE
);
    localparam int L = PRM_AXIS_WIDTH / PRM_COEF_WIDTH;
    localparam int K = PRM_COEF_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PRM_AXIS_WIDTH-1:0] hold_data_q;
    logic [L-1:0]              lane_rem_q;
    logic                      hold_full_q;
    logic                      hold_last_q;
    logic [PRM_ADDR-1:0]       addr_q;
    logic [3:0]                poly_q;
    logic [3:0]                npoly_q;
    logic                      err_len_q;
    logic                      err_keep_q;

    logic [L-1:0]              in_full;
    logic [L-1:0]              in_mixed;
    logic [L-1:0]              rem_next;
    logic [PRM_COEF_WIDTH-1:0] cur_data;
    logic [3:0]                npoly_eff;
    logic                      coef_valid;
    logic                      coef_fire;
    logic                      s_fire;
    logic                      final_lane;
    logic                      last_poly;
    logic                      is_last;
    logic                      tready;

    always_comb begin
        in_full  = '0;
        in_mixed = '0;
        for (int i = 0; i < L; i++) begin
            in_full[i]  = &bus.s_axis_tkeep[i*K +: K];
            in_mixed[i] = (|bus.s_axis_tkeep[i*K +: K]) && !(&bus.s_axis_tkeep[i*K +: K]);
        end
    end

    // Current lane is the lowest still-pending keep-valid lane, so skipped lanes cost no cycles.
    always_comb begin
        cur_data = '0;
        for (int i = L - 1; i >= 0; i--) begin
            if (lane_rem_q[i]) cur_data = hold_data_q[i*PRM_COEF_WIDTH +: PRM_COEF_WIDTH];
        end
    end

    assign rem_next   = lane_rem_q & (lane_rem_q - L'(1));
    assign final_lane = (rem_next == '0);
    assign coef_valid = (state_q == ST_RUN) && hold_full_q;
    assign coef_fire  = coef_valid && bus.coef_ready;
    assign last_poly  = coef_valid && (addr_q == PRM_ADDR'(PRM_COEFFS - 1));
    assign is_last    = last_poly && (poly_q == npoly_q - 4'd1);
    assign npoly_eff  = (iCTL_NPOLY == 4'd0 || iCTL_NPOLY > 4'(PRM_MAX_POLY)) ? 4'd1 : iCTL_NPOLY;

    // A TLAST holder never refills: the frame ends with it.
    assign tready = ((state_q == ST_RUN) &&
                     (!hold_full_q || (coef_fire && final_lane && !is_last && !hold_last_q)))
                    || (state_q == ST_DRAIN);
    assign s_fire = bus.s_axis_tvalid && tready;

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (iCTL_START) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (coef_fire && is_last)                               state_d = hold_last_q ? ST_DONE : ST_DRAIN;
                else if (coef_fire && final_lane && hold_last_q)        state_d = ST_DONE;
                else if (s_fire && in_full == '0 && bus.s_axis_tlast)   state_d = ST_DONE;
            end
            ST_DRAIN: begin
                if (s_fire && bus.s_axis_tlast) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            hold_data_q <= '0;
            lane_rem_q  <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            addr_q      <= '0;
            poly_q      <= '0;
            npoly_q     <= '0;
            err_len_q   <= 1'b0;
            err_keep_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iCTL_START) begin
                        npoly_q     <= npoly_eff;
                        addr_q      <= '0;
                        poly_q      <= '0;
                        err_len_q   <= 1'b0;
                        err_keep_q  <= 1'b0;
                        hold_full_q <= 1'b0;
                        hold_last_q <= 1'b0;
                        lane_rem_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (coef_fire) begin
                        addr_q     <= addr_q + PRM_ADDR'(1);
                        lane_rem_q <= rem_next;
                        if (last_poly) poly_q <= poly_q + 4'd1;
                        if (is_last) begin
                            hold_full_q <= 1'b0;
                            lane_rem_q  <= '0;
                            if (!hold_last_q) err_len_q <= 1'b1;
                        end else if (final_lane) begin
                            hold_full_q <= 1'b0;
                            if (hold_last_q) err_len_q <= 1'b1;
                        end
                    end
                    // An all-empty beat never occupies the holder.
                    if (s_fire) begin
                        hold_data_q <= bus.s_axis_tdata;
                        hold_last_q <= bus.s_axis_tlast;
                        lane_rem_q  <= in_full;
                        hold_full_q <= |in_full;
                        if (|in_mixed) err_keep_q <= 1'b1;
                        if (in_full == '0 && bus.s_axis_tlast) err_len_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s_axis_tready   = tready;
    assign bus.coef_valid      = coef_valid;
    assign bus.coef_data       = cur_data;
    assign bus.coef_addr       = addr_q;
    assign bus.coef_poly       = poly_q;
    assign bus.coef_last_poly  = last_poly;
    assign bus.coef_last       = is_last;
    assign oBUSY               = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign oDONE               = (state_q == ST_DONE);
    assign oERR_LEN            = err_len_q;
    assign oERR_KEEP           = err_keep_q;
    assign oDBG_STATE          = state_q;
endmodule

// File: tb/tb_mdl_axis_coef_unpack.sv
// Bench for mdl_axis_coef_unpack with small parameters (8 coefficients per polynomial, 2 lanes).
// A frame-level model turns the beat list into the expected coefficient stream and error flags.
module tb_mdl_axis_coef_unpack;
    localparam int AW = 64;
    localparam int CW = 32;
    localparam int NC = 8;
    localparam int AD = 3;
    localparam int MP = 4;
    localparam int L  = AW / CW;
    localparam int KW = AW / 8;
    localparam int TW = CW + AD + 6;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] npoly_in;
    logic       busy, done, err_len, err_keep;
    logic [1:0] dbg_state;

    mdl_axis_coef_unpack_if #(.PRM_AXIS_WIDTH(AW), .PRM_COEF_WIDTH(CW), .PRM_ADDR(AD)) bus ();

    mdl_axis_coef_unpack #(
        .PRM_AXIS_WIDTH(AW), .PRM_COEF_WIDTH(CW), .PRM_COEFFS(NC), .PRM_ADDR(AD), .PRM_MAX_POLY(MP)
    ) dut (
        .iSYS_CLK(clk), .iSYS_RST(rst_n), .iCTL_START(start), .iCTL_NPOLY(npoly_in),
        .bus(bus), .oBUSY(busy), .oDONE(done), .oERR_LEN(err_len), .oERR_KEEP(err_keep),
        .oDBG_STATE(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus beats
    logic [AW-1:0] bt_data[$];
    logic [KW-1:0] bt_keep[$];
    logic          bt_last[$];

    // model output
    logic [CW-1:0] exp_q[$];
    int            exp_needed;
    logic          exp_err_len, exp_err_keep;

    // observations
    logic [CW-1:0] obs_data[$];
    logic [AD-1:0] obs_addr[$];
    logic [3:0]    obs_poly[$];
    logic          obs_lp[$];
    logic          obs_l[$];
    int            obs_cyc[$];
    int            first_acc_cyc, done_cyc, done_cnt, beats_taken, stall_bad;
    logic          timeout, busy_at_done, fin_err_len, fin_err_keep;

    task automatic clear_beats();
        bt_data.delete(); bt_keep.delete(); bt_last.delete();
    endtask

    task automatic add_beat(input logic [AW-1:0] d, input logic [KW-1:0] k, input logic lst);
        bt_data.push_back(d); bt_keep.push_back(k); bt_last.push_back(lst);
    endtask

    // Frame-level reference: walk beats, emit fully-kept lanes until the frame is full or TLAST arrives.
    task automatic build_expected(input int npoly);
        int npe, cnt;
        bit ended;
        logic [KW-1:0] kv;
        logic [AW-1:0] dv;
        npe = (npoly == 0 || npoly > MP) ? 1 : npoly;
        exp_needed = npe * NC;
        exp_q.delete();
        exp_err_len = 0; exp_err_keep = 0; cnt = 0; ended = 0;
        for (int b = 0; b < bt_data.size() && !ended; b++) begin
            for (int ln = 0; ln < L; ln++) begin
                kv = bt_keep[b] >> (ln * 4);
                dv = bt_data[b] >> (ln * CW);
                if (kv[3:0] == 4'hF && cnt < exp_needed) begin
                    exp_q.push_back(dv[CW-1:0]);
                    cnt++;
                end else if (kv[3:0] != 4'h0 && kv[3:0] != 4'hF) begin
                    exp_err_keep = 1;
                end
            end
            if (cnt == exp_needed) begin
                ended = 1;
                exp_err_len = !bt_last[b];
            end else if (bt_last[b]) begin
                ended = 1;
                exp_err_len = 1;
            end
        end
    endtask

    // Drives one frame: inputs change 1 time unit after posedge, everything is sampled at negedge.
    task automatic run_frame(input int npoly, input bit rdy_rand, input int gap_pct,
                             input int stop_after, input bit start_mid);
        int bi, cyc;
        bit acc, fin, pv, pr;
        logic [TW-1:0] psnap, csnap;
        obs_data.delete(); obs_addr.delete(); obs_poly.delete();
        obs_lp.delete(); obs_l.delete(); obs_cyc.delete();
        first_acc_cyc = -1; done_cyc = -1; done_cnt = 0; beats_taken = 0; stall_bad = 0;
        timeout = 0; busy_at_done = 0;
        pv = 0; pr = 0; psnap = '0;
        @(posedge clk); #1;
        start = 1'b1; npoly_in = 4'(npoly);
        @(posedge clk); #1;
        start = 1'b0;
        bi = 0; cyc = 0; fin = 0;
        while (!fin) begin
            if (!bus.s_axis_tvalid && bi < bt_data.size() && $urandom_range(99) >= gap_pct) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tdata  = bt_data[bi];
                bus.s_axis_tkeep  = bt_keep[bi];
                bus.s_axis_tlast  = bt_last[bi];
            end
            bus.coef_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
            if (start_mid && cyc == 3) begin start = 1'b1; npoly_in = 4'd1; end
            else start = 1'b0;
            @(negedge clk);
            acc = bus.s_axis_tvalid && bus.s_axis_tready;
            if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
            csnap = {bus.coef_valid, bus.coef_data, bus.coef_addr, bus.coef_poly,
                     bus.coef_last_poly, bus.coef_last};
            if (pv && !pr && csnap !== psnap) stall_bad++;
            pv = bus.coef_valid; pr = bus.coef_ready; psnap = csnap;
            if (bus.coef_valid && bus.coef_ready) begin
                obs_data.push_back(bus.coef_data); obs_addr.push_back(bus.coef_addr);
                obs_poly.push_back(bus.coef_poly); obs_lp.push_back(bus.coef_last_poly);
                obs_l.push_back(bus.coef_last); obs_cyc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
            @(posedge clk); #1;
            if (acc) begin bi++; beats_taken++; bus.s_axis_tvalid = 1'b0; end
            cyc++;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1;
            if (stop_after > 0 && obs_data.size() >= stop_after) fin = 1;
            if (cyc >= 3000) begin timeout = 1; fin = 1; end
        end
        bus.s_axis_tvalid = 1'b0; bus.coef_ready = 1'b0; start = 1'b0;
        fin_err_len = err_len; fin_err_keep = err_keep;
    endtask

    task automatic test_reset();
        logic [TW+6:0] got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {bus.s_axis_tready, bus.coef_valid, bus.coef_last, bus.coef_last_poly, busy, done,
               err_len, err_keep, bus.coef_addr, bus.coef_poly, bus.coef_data, dbg_state};
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", got); end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got busy=%b tready=%b want 0 0", busy, bus.s_axis_tready);
        end
    endtask

    task automatic test_match();
        logic [TW-1:0] got, want;
        clear_beats();
        for (int k = 0; k < 4; k++) add_beat({32'(2*k+1), 32'(2*k)}, 8'hFF, k == 3);
        build_expected(1);
        run_frame(1, 0, 0, 0, 0);
        total++;
        if (obs_data.size() !== exp_q.size()) begin bad++; $display("FAIL match count: got %0d want %0d", obs_data.size(), exp_q.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            got  = {obs_data[i], obs_addr[i], obs_poly[i], obs_lp[i], obs_l[i]};
            want = {exp_q[i], AD'(i % NC), 4'(i / NC), i % NC == NC - 1, i == exp_needed - 1};
            total++;
            if (got !== want) begin bad++; $display("FAIL match coef%0d: got %h want %h", i, got, want); end
            total++;
            if (obs_cyc[i] !== first_acc_cyc + 1 + i) begin bad++; $display("FAIL match cycle%0d: got %0d want %0d", i, obs_cyc[i], first_acc_cyc + 1 + i); end
        end
        if (obs_cyc.size() > 0) begin
            total++;
            if (done_cyc !== obs_cyc[obs_cyc.size()-1] + 1) begin bad++; $display("FAIL match done_cycle: got %0d want %0d", done_cyc, obs_cyc[obs_cyc.size()-1] + 1); end
        end
        total++;
        if ({fin_err_len, fin_err_keep} !== {exp_err_len, exp_err_keep}) begin bad++; $display("FAIL match errs: got %b%b want %b%b", fin_err_len, fin_err_keep, exp_err_len, exp_err_keep); end
        total++;
        if ({done_cnt, busy_at_done, timeout} !== {32'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL match done: got cnt=%0d busy=%b to=%b want 1 0 0", done_cnt, busy_at_done, timeout); end
    endtask

    // Shared shape for the randomised scenarios: sequence, flags, done pulse, stalls and beats consumed.
    task automatic test_frame(input string nm, input int npoly, input bit rdy_rand, input int gap_pct, input bit start_mid);
        logic [TW-1:0] got, want;
        build_expected(npoly);
        run_frame(npoly, rdy_rand, gap_pct, 0, start_mid);
        total++;
        if (obs_data.size() !== exp_q.size()) begin bad++; $display("FAIL %s count: got %0d want %0d", nm, obs_data.size(), exp_q.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++) begin
            got  = {obs_data[i], obs_addr[i], obs_poly[i], obs_lp[i], obs_l[i]};
            want = {exp_q[i], AD'(i % NC), 4'(i / NC), i % NC == NC - 1, i == exp_needed - 1};
            total++;
            if (got !== want) begin bad++; $display("FAIL %s coef%0d: got %h want %h", nm, i, got, want); end
        end
        total++;
        if (fin_err_len !== exp_err_len) begin bad++; $display("FAIL %s err_len: got %b want %b", nm, fin_err_len, exp_err_len); end
        total++;
        if (fin_err_keep !== exp_err_keep) begin bad++; $display("FAIL %s err_keep: got %b want %b", nm, fin_err_keep, exp_err_keep); end
        total++;
        if ({done_cnt, busy_at_done, timeout} !== {32'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL %s done: got cnt=%0d busy=%b to=%b want 1 0 0", nm, done_cnt, busy_at_done, timeout); end
        total++;
        if (stall_bad !== 0) begin bad++; $display("FAIL %s stall_stable: got %0d changes want 0", nm, stall_bad); end
        total++;
        if (beats_taken !== bt_data.size()) begin bad++; $display("FAIL %s beats: got %0d want %0d", nm, beats_taken, bt_data.size()); end
    endtask

    task automatic test_backpressure();
        clear_beats();
        for (int k = 0; k < 4; k++) add_beat({32'(2*k+1), 32'(2*k)}, 8'hFF, k == 3);
        test_frame("backpressure", 1, 1, 40, 0);
    endtask

    task automatic test_multi_poly();
        clear_beats();
        for (int k = 0; k < 8; k++) add_beat({$urandom, $urandom}, 8'hFF, k == 7);
        test_frame("multi_poly", 2, 1, 20, 1);
    endtask

    task automatic test_length();
        clear_beats();
        for (int k = 0; k < 3; k++) add_beat({$urandom, $urandom}, 8'hFF, k == 2);
        test_frame("len_short", 1, 1, 10, 0);
        clear_beats();
        for (int k = 0; k < 6; k++) add_beat({$urandom, $urandom}, 8'hFF, k == 5);
        test_frame("len_long", 1, 0, 0, 0);
    endtask

    task automatic test_keep();
        clear_beats();
        add_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        add_beat({$urandom, $urandom}, 8'h0F, 1'b0);
        add_beat({$urandom, $urandom}, 8'h3F, 1'b0);
        add_beat({$urandom, $urandom}, 8'h00, 1'b0);
        add_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        add_beat({$urandom, $urandom}, 8'hFF, 1'b1);
        test_frame("keep", 1, 1, 25, 0);
    endtask

    task automatic test_npoly_clamp();
        int vals[2] = '{0, 9};
        foreach (vals[j]) begin
            clear_beats();
            for (int k = 0; k < 4; k++) add_beat({$urandom, $urandom}, 8'hFF, k == 3);
            test_frame($sformatf("npoly_%0d", vals[j]), vals[j], 1, 15, 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [TW+6:0] got;
        clear_beats();
        for (int k = 0; k < 4; k++) add_beat({32'(2*k+1), 32'(2*k)}, 8'hFF, k == 3);
        run_frame(1, 0, 0, 3, 0);
        total++;
        if (obs_data.size() !== 3) begin bad++; $display("FAIL reset_mid pre: got %0d coefs want 3", obs_data.size()); end
        rst_n = 1'b0;
        @(negedge clk);
        got = {bus.s_axis_tready, bus.coef_valid, bus.coef_last, bus.coef_last_poly, busy, done,
               err_len, err_keep, bus.coef_addr, bus.coef_poly, bus.coef_data, dbg_state};
        total++;
        if (got !== '0) begin bad++; $display("FAIL reset_mid outputs: got %h want 0", got); end
        rst_n = 1'b1;
        test_frame("reset_mid_restart", 1, 1, 20, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; npoly_in = 4'd0;
        bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0;
        bus.s_axis_tlast = 1'b0; bus.coef_ready = 1'b0;
        test_reset();
        test_match();
        test_backpressure();
        test_multi_poly();
        test_length();
        test_keep();
        test_npoly_clamp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
